mitch_mac_acc: RTL
==================

MITCH_MAC_ACC -- requirements
Module: mitch_mac_acc

Interface
REQ-001: Parameter LEN, default 16; products per dot-product frame; legal range 1..256.
REQ-002: Parameter ACC_W, default 40; accumulator width; legal range 33..48.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: in_valid  input  1  product beat valid.
REQ-006: in_ready  output  1  block accepts a beat this cycle.
REQ-007: in_p  input  32  approximate product from the 16x16 log multiplier, one's-complement encoded when negative.
REQ-008: in_neg  input  1  product sign, equal to x[15]^y[15] of the multiplier operands.
REQ-009: in_last  input  1  beat closes the frame early; sampled only on handshake.
REQ-010: out_valid  output  1  frame result valid.
REQ-011: out_ready  input  1  downstream accepts result.
REQ-012: out_acc  output  ACC_W  signed two's-complement frame sum.
REQ-013: out_sat  output  1  frame saturated at least once.
REQ-014: out_cnt  output  9  number of beats summed into out_acc (1..LEN).

Function
REQ-015: Input handshake occurs in a cycle with in_valid=1 and in_ready=1; output handshake occurs with out_valid=1 and out_ready=1.
REQ-016: States: ACC (collecting) and HOLD (result presented); reset state ACC.
REQ-017: ACC: in_ready=1, out_valid=0; HOLD: in_ready=0, out_valid=1.
REQ-018: Term per beat: T = sign-extend(in_p) to ACC_W, plus 1 when in_neg=1 and in_p != 0 (one's- to two's-complement correction); in_neg=1 with in_p=0 yields T=0.
REQ-019: On each input handshake: acc <= sat(acc + T), cnt <= cnt + 1; addition computed at ACC_W+1 bits.
REQ-020: sat(): result above 2^(ACC_W-1)-1 clamps to that value, below -2^(ACC_W-1) clamps to that value; any clamp sets sticky sat flag.
REQ-021: ACC -> HOLD on input handshake where cnt+1 == LEN or in_last=1; result registered the same edge, so out_valid rises one cycle after the closing beat.
REQ-022: In HOLD, out_acc, out_sat, out_cnt stable until output handshake; in_p/in_neg/in_last ignored.
REQ-023: HOLD -> ACC on output handshake; same edge clears acc, cnt, sat flag; in_ready=1 in the following cycle (one bubble per frame).
REQ-024: in_valid=0 in ACC: no state change; gaps of any length inside a frame permitted.
REQ-025: LEN=1: every accepted beat closes a frame.
REQ-026: in_last with cnt+1 == LEN: single frame close, no extra empty frame.
REQ-027: out_acc, out_sat, out_cnt hold last frame values outside HOLD; only meaningful while out_valid=1.
REQ-028: No combinational path from in_valid/out_ready to in_ready/out_valid; both are decoded from the state register.

Reset
REQ-029: rst_n low asynchronously forces state ACC, acc=0, cnt=0, sat flag=0, out_valid=0, out_acc=0, out_sat=0, out_cnt=0.
REQ-030: in_ready goes to 1 asynchronously with rst_n low (reset state ACC); no beat accepted while rst_n low.
REQ-031: Reset during HOLD discards the pending result; reset mid-frame discards partial sum; first post-reset beat starts a fresh frame.
REQ-032: rst_n deassertion is synchronous to clk by the surrounding system; no internal synchronizer.

Verification
REQ-033: LEN=4, beats in_p={100,200,300,400}, in_neg=0, out_ready=1 -> out_valid one cycle after 4th beat, out_acc=1000, out_cnt=4, out_sat=0.
REQ-034: LEN=4, beats (in_p=0xFFFFFF9B,in_neg=1), (50,0), (0,1), (0,0) -> T=-100,50,0,0; out_acc=-50, out_cnt=4.
REQ-035: LEN=16, 3 beats of 7, in_last on 3rd -> out_acc=21, out_cnt=3; next frame starts from 0.
REQ-036: ACC_W=33, LEN=4, four beats in_p=0x7FFFFFFF -> out_acc=0x0FFFFFFFF (2^32-1), out_sat=1; following frame out_sat=0.
REQ-037: Frame closes with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable all 5 cycles, no beat lost; accept resumes cycle after out_ready=1.
REQ-038: rst_n pulsed low mid-frame after 2 of 4 beats, then 4 beats of 1 -> out_acc=4, out_cnt=4; rst_n low in HOLD drops out_valid immediately.

Source files
------------

// File: rtl/mitch_mac_acc.sv
// Saturating dot-product accumulator for a 16x16 log multiplier.
// Sums one product per beat and hands out one result per frame.
module mitch_mac_acc #(
    parameter int LEN   = 16,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p,
    input  logic             in_neg,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic [8:0]       out_cnt
);

    typedef enum logic {ST_ACC, ST_HOLD} state_e;

    localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [8:0]       cnt_q;
    logic [8:0]       cnt_d;
    logic             sat_q;
    logic             sat_d;
    logic [ACC_W-1:0] out_acc_q;
    logic             out_sat_q;
    logic [8:0]       out_cnt_q;

    logic [ACC_W:0]   term;
    logic [ACC_W:0]   sum;
    logic             clamp;
    logic             close;

    // One's-complement negatives need +1; a negative zero stays zero.
    assign term = {{(ACC_W+1-32){in_p[31]}}, in_p}
                + {{ACC_W{1'b0}}, (in_neg && (in_p != 32'd0))};
    assign sum  = {acc_q[ACC_W-1], acc_q} + term;

    always_comb begin
        clamp = sum[ACC_W] ^ sum[ACC_W-1];
        acc_d = sum[ACC_W-1:0];
        if (clamp) begin
            acc_d = sum[ACC_W] ? MINV : MAXV;
        end
    end

    assign cnt_d = cnt_q + 9'd1;
    assign sat_d = sat_q | clamp;
    assign close = in_last || (cnt_d == 9'(LEN));

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_acc   = out_acc_q;
    assign out_sat   = out_sat_q;
    assign out_cnt   = out_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            out_acc_q <= '0;
            out_sat_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        sat_q <= sat_d;
                        if (close) begin
                            state_q   <= ST_HOLD;
                            out_acc_q <= acc_d;
                            out_sat_q <= sat_d;
                            out_cnt_q <= cnt_d;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q <= ST_ACC;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

endmodule
